// File: rtl/flit_ecc_scheduler.sv
// Flit ECC scheduler: collects a 250-byte flit in 8 beats, runs three interleaved
// 84-byte groups through a shared external encoder, appends the check and parity
// bytes and emits the resulting 256-byte flit in 8 beats.
module flit_ecc_scheduler #(
   parameter logic [7:0] PAD_BYTE = 8'h00
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [255:0] in_data,
   input  logic         in_last,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [255:0] out_data,
   output logic         out_last,
   output logic [671:0] enc_data,
   input  logic [7:0]   enc_check,
   input  logic [7:0]   enc_parity,
   output logic         err
);

   typedef enum logic [2:0] {COLLECT, ENC0, ENC1, ENC2, EMIT} state_t;

   state_t            state_q, state_d;
   logic [2:0]        in_cnt_q, in_cnt_d;
   logic [2:0]        out_cnt_q, out_cnt_d;
   logic [7:0][255:0] buf_q, buf_d;
   logic [2047:0]     buf_flat;
   logic              in_ready_q, in_ready_d;
   logic              out_valid_q, out_valid_d;
   logic              out_last_q, out_last_d;
   logic              err_q, err_d;

   // Buffer holds the whole output flit: beat 7 bytes 26..31 are overwritten by
   // the captured ECC bytes, so out_data is a plain beat select.
   assign buf_flat  = buf_q;
   assign out_data  = buf_q[out_cnt_q];
   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_last  = out_last_q;
   assign err       = err_q;

   // Present group g to the encoder: byte j is flit byte 3j+g, padded past byte 249
   always_comb begin
      int unsigned g;
      int unsigned idx;
      g   = 0;
      idx = 0;
      case (state_q)
         ENC1:    g = 1;
         ENC2:    g = 2;
         default: g = 0;
      endcase
      enc_data = '0;
      for (int unsigned j = 0; j < 84; j++) begin
         idx = 3 * j + g;
         if (idx <= 249) enc_data[8*j +: 8] = buf_flat[8*idx +: 8];
         else            enc_data[8*j +: 8] = PAD_BYTE;
      end
   end

   // Next-state logic: collect, encode three groups, then emit
   always_comb begin
      state_d   = state_q;
      in_cnt_d  = in_cnt_q;
      out_cnt_d = out_cnt_q;
      buf_d     = buf_q;
      err_d     = 1'b0;
      case (state_q)
         COLLECT: begin
            if (in_valid && in_ready_q) begin
               buf_d[in_cnt_q] = in_data;
               if (in_cnt_q == 3'd7) begin
                  in_cnt_d = '0;
                  if (in_last) state_d = ENC0;
                  else         err_d   = 1'b1;
               end else if (in_last) begin
                  in_cnt_d = '0;
                  err_d    = 1'b1;
               end else begin
                  in_cnt_d = in_cnt_q + 3'd1;
               end
            end
         end
         ENC0: begin
            buf_d[7][8*26 +: 8] = enc_check;
            buf_d[7][8*29 +: 8] = enc_parity;
            state_d             = ENC1;
         end
         ENC1: begin
            buf_d[7][8*27 +: 8] = enc_check;
            buf_d[7][8*30 +: 8] = enc_parity;
            state_d             = ENC2;
         end
         ENC2: begin
            buf_d[7][8*28 +: 8] = enc_check;
            buf_d[7][8*31 +: 8] = enc_parity;
            state_d             = EMIT;
         end
         EMIT: begin
            if (out_valid_q && out_ready) begin
               if (out_cnt_q == 3'd7) begin
                  out_cnt_d = '0;
                  state_d   = COLLECT;
               end else begin
                  out_cnt_d = out_cnt_q + 3'd1;
               end
            end
         end
         default: state_d = COLLECT;
      endcase
      in_ready_d  = (state_d == COLLECT);
      out_valid_d = (state_d == EMIT);
      out_last_d  = (state_d == EMIT) && (out_cnt_d == 3'd7);
   end

   // State and registered outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= COLLECT;
         in_cnt_q    <= '0;
         out_cnt_q   <= '0;
         buf_q       <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         in_cnt_q    <= in_cnt_d;
         out_cnt_q   <= out_cnt_d;
         buf_q       <= buf_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         err_q       <= err_d;
      end
   end

endmodule

// File: tb/tb_flit_ecc_scheduler.sv
// Scoreboard bench for flit_ecc_scheduler with a behavioural encoder and flit model.
module tb_flit_ecc_scheduler;

   localparam logic [7:0] PAD = 8'h00;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [255:0] in_data = '0;
   logic         in_last = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [255:0] out_data;
   logic         out_last;
   logic [671:0] enc_data;
   logic [7:0]   enc_check;
   logic [7:0]   enc_parity;
   logic         err;

   flit_ecc_scheduler #(.PAD_BYTE(PAD)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
      .enc_data(enc_data), .enc_check(enc_check), .enc_parity(enc_parity), .err(err)
   );

   always #5 clk = ~clk;

   typedef logic [7:0] flit_t [250];
   typedef struct {
      logic [255:0] data;
      logic         last;
      int           beat;
      int           due;
   } exp_t;

   exp_t exp_q[$];
   exp_t e;
   int   vectors = 0;
   int   miscompares = 0;
   int   cyc = 0;
   int   err_due = -10;
   bit   mon_en = 0;
   bit   seen = 0;
   bit   gap_en = 0;
   bit   rdy_rand = 0;

   // Encoder model: weighted byte sum as check, XOR of bytes as parity
   function automatic logic [7:0] chk_fn(input logic [671:0] d);
      logic [7:0] s = '0;
      for (int j = 0; j < 84; j++) s = s + 8'((j + 1) * int'(d[8*j +: 8]));
      return s;
   endfunction

   function automatic logic [7:0] par_fn(input logic [671:0] d);
      logic [7:0] p = '0;
      for (int j = 0; j < 84; j++) p = p ^ d[8*j +: 8];
      return p;
   endfunction

   assign enc_check  = chk_fn(enc_data);
   assign enc_parity = par_fn(enc_data);

   function automatic logic [671:0] group_of(input flit_t f, input int g);
      logic [671:0] r;
      for (int j = 0; j < 84; j++) begin
         int n;
         n = 3 * j + g;
         r[8*j +: 8] = (n < 250) ? f[n] : PAD;
      end
      return r;
   endfunction

   function automatic logic [255:0] in_beat(input flit_t f, input int k);
      logic [255:0] r;
      for (int b = 0; b < 32; b++) begin
         int n;
         n = 32 * k + b;
         r[8*b +: 8] = (n < 250) ? f[n] : 8'($urandom);
      end
      return r;
   endfunction

   task automatic check(input string name, input logic [671:0] act, input logic [671:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push_expected(input flit_t f, input int hs);
      logic [7:0] ob [256];
      exp_t x;
      for (int i = 0; i < 250; i++) ob[i] = f[i];
      for (int g = 0; g < 3; g++) begin
         ob[250 + g] = chk_fn(group_of(f, g));
         ob[253 + g] = par_fn(group_of(f, g));
      end
      for (int k = 0; k < 8; k++) begin
         for (int b = 0; b < 32; b++) x.data[8*b +: 8] = ob[32*k + b];
         x.last = (k == 7);
         x.beat = k;
         x.due  = hs + 4;
         exp_q.push_back(x);
      end
   endtask

   // bad_beat: -1 well formed, 0..6 early in_last, 7 missing in_last
   task automatic send_flit(input flit_t f, input int bad_beat);
      for (int k = 0; k < 8; k++) begin
         int gap;
         int n;
         gap = (gap_en && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
         repeat (gap) begin
            in_valid = 1'b0;
            in_data  = {8{$urandom}};
            @(posedge clk); #1;
         end
         in_valid = 1'b1;
         in_data  = in_beat(f, k);
         in_last  = (bad_beat == k) ? (k != 7) : (k == 7);
         n = 0;
         forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 300) begin
               miscompares++;
               $display("FAIL in_ready_timeout: got 0 expected 1 (beat %0d)", k);
               in_valid = 1'b0;
               return;
            end
         end
         if (bad_beat == k) err_due = cyc + 1;
         else if (k == 7) push_expected(f, cyc);
         @(posedge clk); #1;
         in_valid = 1'b0;
         in_last  = 1'b0;
         if (bad_beat == k) return;
      end
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 500) begin
         @(posedge clk); #1;
         n++;
      end
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL drain_timeout: got %0d beats pending expected 0", exp_q.size());
         exp_q.delete();
         seen = 0;
      end
   endtask

   function automatic flit_t rand_flit();
      flit_t f;
      for (int i = 0; i < 250; i++) f[i] = 8'($urandom);
      return f;
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Random backpressure when enabled
   initial begin
      forever begin
         @(posedge clk); #1;
         if (rdy_rand) out_ready = ($urandom_range(0, 3) != 0);
      end
   end

   // Monitor: compare every presented output beat with the scoreboard head
   always @(negedge clk) begin
      if (mon_en) begin
         check("err", 672'(err), 672'(cyc == err_due));
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL unexpected_out: got out_valid=1 expected 0 (cycle %0d)", cyc);
            end else begin
               e = exp_q[0];
               if (e.beat == 0 && !seen) begin
                  check("latency", 672'(cyc), 672'(e.due));
                  seen = 1;
               end
               check("out_data", 672'(out_data), 672'(e.data));
               check("out_last", 672'(out_last), 672'(e.last));
               if (out_ready) begin
                  void'(exp_q.pop_front());
                  seen = 0;
               end
            end
         end
      end
   end

   initial begin
      flit_t f;
      int    n;

      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("rst_in_ready", 672'(in_ready), 672'(1'b1));
      check("rst_out_valid", 672'(out_valid), 672'(1'b0));
      check("rst_out_last", 672'(out_last), 672'(1'b0));
      check("rst_err", 672'(err), 672'(1'b0));
      mon_en = 1;
      @(posedge clk); #1;

      // All-zero flit with out_ready held high
      out_ready = 1'b1;
      for (int i = 0; i < 250; i++) f[i] = 8'h00;
      send_flit(f, -1);
      drain();

      // Byte 0/1 pattern, observe encoder groups directly
      for (int i = 0; i < 250; i++) f[i] = 8'h00;
      f[0] = 8'h01;
      f[1] = 8'hA5;
      send_flit(f, -1);
      @(negedge clk);
      check("enc_g0_byte0", 672'(enc_data[7:0]), 672'(8'h01));
      check("enc_g0", enc_data, group_of(f, 0));
      @(negedge clk);
      check("enc_g1_byte0", 672'(enc_data[7:0]), 672'(8'hA5));
      check("enc_g1", enc_data, group_of(f, 1));
      @(negedge clk);
      check("enc_g2", enc_data, group_of(f, 2));
      drain();

      // Five-cycle stall while beat 3 is presented
      out_ready = 1'b0;
      f = rand_flit();
      send_flit(f, -1);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!out_valid && n < 20);
      check("stall_out_valid_seen", 672'(out_valid), 672'(1'b1));
      @(posedge clk); #1;
      out_ready = 1'b1;
      repeat (3) begin @(posedge clk); #1; end
      out_ready = 1'b0;
      repeat (5) begin @(posedge clk); #1; end
      out_ready = 1'b1;
      drain();

      // Framing errors: early in_last, then missing in_last, then a good flit
      f = rand_flit();
      send_flit(f, 4);
      repeat (3) begin @(posedge clk); #1; end
      f = rand_flit();
      send_flit(f, 7);
      repeat (3) begin @(posedge clk); #1; end
      f = rand_flit();
      send_flit(f, -1);
      drain();

      // Reset during ENC1 discards the flit
      f = rand_flit();
      send_flit(f, -1);
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      exp_q.delete();
      seen = 0;
      @(negedge clk);
      check("post_rst_out_valid", 672'(out_valid), 672'(1'b0));
      check("post_rst_in_ready", 672'(in_ready), 672'(1'b1));
      @(posedge clk); #1;
      f = rand_flit();
      send_flit(f, -1);
      drain();

      // Random flits with random input gaps and backpressure
      gap_en   = 1;
      rdy_rand = 1;
      for (int i = 0; i < 1000; i++) begin
         f = rand_flit();
         send_flit(f, -1);
      end
      drain();
      rdy_rand = 0;
      repeat (4) @(posedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
